nibble_add_seq: RTL and testbench



---
 rtl/nibble_add_seq_pkg.sv | 29 ++
 rtl/adder4c.sv | 35 +++
 rtl/full_adder.sv | 21 ++
 rtl/nibble_add_seq.sv | 145 ++++++++++++++
 tb/tb_nibble_add_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// nibble_add_seq_pkg
// Shared definitions for the nibble-serial adder controller:
//   - NIB_W      : width of one nibble slice handled by the shared adder
//   - state_e    : controller states (IDLE, RUN, DONE)
//   - idx_width(): width of the nibble index counter for a given nibble count
// -----------------------------------------------------------------------------
package nibble_add_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-nibble build still needs a 1-bit index so the counter exists.
    function automatic int idx_width(input int nibbles);
        int w;
        if (nibbles > 1) begin
            w = $clog2(nibbles);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder4c.sv
// -----------------------------------------------------------------------------
// adder4c
// Combinational 4-bit ripple-carry adder with carry in, built from four
// full_adder cells chained LSB to MSB.
// Ports:
//   A[3:0], B[3:0] : addends
//   CI             : carry in
//   S[3:0]         : 4-bit sum
//   CO             : carry out of bit 3
// -----------------------------------------------------------------------------
module adder4c (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CI,
    output logic [3:0] S,
    output logic       CO
);

    // c[i] is the carry into bit i; c[4] leaves the adder.
    logic [4:0] c;

    assign c[0] = CI;
    assign CO   = c[4];

    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// 1-bit full-adder cell used as the building block of the ripple adder.
// Ports:
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/nibble_add_seq.sv
// -----------------------------------------------------------------------------
// nibble_add_seq
// Adds two W-bit unsigned operands (W = 4*NIBBLES) over several cycles using a
// single 4-bit ripple adder, least-significant nibble first, with the carry
// between nibbles held in a register. {cout,sum} ends up equal to a + b.
// Parameters:
//   NIBBLES : nibbles per operand (>= 1)
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request an addition; only looked at in IDLE
//   a, b  : operands, captured when start is accepted
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse when the result is complete
//   sum   : result, valid from done until the next accepted start
//   cout  : carry out of the top nibble, same validity as sum
// -----------------------------------------------------------------------------
module nibble_add_seq
    import nibble_add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Shared adder slice inputs/outputs for the nibble selected by idx_q.
    logic [NIB_W-1:0] nib_a, nib_b, nib_s;
    logic             nib_co;

    // Select the current operand nibbles for the shared adder.
    always_comb begin
        nib_a = a_q[NIB_W*idx_q +: NIB_W];
        nib_b = b_q[NIB_W*idx_q +: NIB_W];
    end

    adder4c u_adder (
        .A  (nib_a),
        .B  (nib_b),
        .CI (carry_q),
        .S  (nib_s),
        .CO (nib_co)
    );

    // Next-state and datapath update for the controller.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    idx_d   = {IDX_W{1'b0}};
                    sum_d   = {W{1'b0}};
                    cout_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[NIB_W*idx_q +: NIB_W] = nib_s;
                carry_d                     = nib_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_co;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Controller, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_seq
// Directed self-checking bench for nibble_add_seq. A 4-nibble instance covers
// the main function, start handling and mid-operation reset; a 1-nibble
// instance covers the minimum configuration. Expected results are queued
// when an operation is launched and compared when done is observed.
// -----------------------------------------------------------------------------
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start4;
    logic [15:0] a4, b4, sum4;
    logic        busy4, done4, cout4;

    logic        start1;
    logic [3:0]  a1, b1, sum1;
    logic        busy1, done1, cout1;

    int          checks = 0;
    int          errors = 0;
    int          pulses;
    int          n1;
    int          busy1_cnt;
    bit          got1;

    logic [16:0] sb[$];

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    nibble_add_seq #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start high and queue the reference result.
    task automatic launch(input logic [15:0] ta, input logic [15:0] tbv);
        a4     = ta;
        b4     = tbv;
        start4 = 1'b1;
        sb.push_back({1'b0, ta} + {1'b0, tbv});
    endtask

    // Called at the negedge where start is high in IDLE; waits for done.
    task automatic wait_result(input string tag, input bit hold, input bit inject);
        int          n;
        int          busy_cnt;
        bit          got;
        logic [16:0] exp;
        n        = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busy4) busy_cnt++;
            if (done4) got = 1'b1;
            if (!hold) start4 = 1'b0;
            if (inject && n == 2) begin
                start4 = 1'b1;
                a4     = 16'h1111;
                b4     = 16'h1111;
            end
        end
        chk({tag, "_latency"}, got ? n : -1, 32'd5);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
        end else begin
            exp = 17'h1ffff;
        end
        if (got) begin
            chk({tag, "_sum"}, {16'h0, sum4}, {16'h0, exp[15:0]});
            chk({tag, "_cout"}, {31'h0, cout4}, {31'h0, exp[16]});
        end
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd5);
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        a4     = 16'h0;
        b4     = 16'h0;
        start1 = 1'b0;
        a1     = 4'h0;
        b1     = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy4}, 32'h0);
        chk("rst_done", {31'h0, done4}, 32'h0);
        chk("rst_sum",  {16'h0, sum4},  32'h0);
        chk("rst_cout", {31'h0, cout4}, 32'h0);
        chk("rst_sum1", {28'h0, sum1},  32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Plain addition, no inter-nibble carries
        launch(16'h1234, 16'h4321);
        wait_result("t1", 1'b0, 1'b0);
        chk("t1_value", {15'h0, cout4, sum4}, 32'h05555);
        @(negedge clk);
        chk("t1_hold_sum", {16'h0, sum4}, 32'h5555);
        chk("t1_idle_busy", {31'h0, busy4}, 32'h0);
        chk("t1_idle_done", {31'h0, done4}, 32'h0);

        // Carry ripples through every nibble
        launch(16'hFFFF, 16'h0001);
        wait_result("t2", 1'b0, 1'b0);
        chk("t2_value", {15'h0, cout4, sum4}, 32'h10000);
        @(negedge clk);

        // start and new operands during RUN are ignored
        launch(16'h00FF, 16'h0001);
        wait_result("t3", 1'b0, 1'b1);
        chk("t3_value", {15'h0, cout4, sum4}, 32'h00100);
        @(negedge clk);
        @(negedge clk);
        chk("t3_not_queued", {31'h0, busy4}, 32'h0);
        launch(16'h1111, 16'h1111);
        wait_result("t3b", 1'b0, 1'b0);
        chk("t3b_value", {15'h0, cout4, sum4}, 32'h02222);
        @(negedge clk);

        // start held high: second accept only after DONE
        launch(16'h8000, 16'h8000);
        wait_result("t4a", 1'b1, 1'b0);
        chk("t4a_value", {15'h0, cout4, sum4}, 32'h10000);
        @(negedge clk);
        chk("t4_idle_after_done", {31'h0, busy4}, 32'h0);
        chk("t4_done_single", {31'h0, done4}, 32'h0);
        sb.push_back({1'b0, a4} + {1'b0, b4});
        wait_result("t4b", 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset two cycles into RUN
        launch(16'h1234, 16'h1111);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", {31'h0, busy4}, 32'h0);
        chk("t5_done", {31'h0, done4}, 32'h0);
        chk("t5_sum",  {16'h0, sum4},  32'h0);
        chk("t5_cout", {31'h0, cout4}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) pulses++;
        end
        chk("t5_no_done", pulses, 32'd0);
        launch(16'h0005, 16'h0003);
        wait_result("t5b", 1'b0, 1'b0);
        chk("t5b_value", {15'h0, cout4, sum4}, 32'h00008);

        // Single-nibble configuration
        @(negedge clk);
        a1        = 4'h9;
        b1        = 4'h8;
        start1    = 1'b1;
        n1        = 0;
        busy1_cnt = 0;
        got1      = 1'b0;
        while (!got1 && n1 < 10) begin
            @(negedge clk);
            n1++;
            start1 = 1'b0;
            if (busy1) busy1_cnt++;
            if (done1) got1 = 1'b1;
        end
        chk("t6_latency", got1 ? n1 : -1, 32'd2);
        chk("t6_sum",  {28'h0, sum1},  32'h1);
        chk("t6_cout", {31'h0, cout1}, 32'h1);
        chk("t6_busy_cycles", busy1_cnt, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
